motor_sequencer: RTL and testbench

Memory-mapped motion controller between the darkriscv data bus and `motor_driver`. It lets firmware program the target speed, acceleration, direction and step count, then runs a trapezoidal ramp on `speed_out`. It counts steps from the driver's `step_out` and raises a done flag or interrupt when the move completes. It decodes its own window in the 0x1000_0000 IO region and returns zero on unselected reads, so the top level can OR read buses.

---
 rtl/motor_seq_pkg.sv | 41 ++++
 rtl/motor_sequencer_ramp_ticker.sv | 27 ++
 rtl/motor_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_motor_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_seq_pkg.sv
// motor_seq_pkg: register map, FSM state encoding and register bit positions
// shared by the motor sequencer and its testbench.
package motor_seq_pkg;

  localparam logic [4:0] OFF_CTRL     = 5'h00;
  localparam logic [4:0] OFF_STATUS   = 5'h04;
  localparam logic [4:0] OFF_TARGET   = 5'h08;
  localparam logic [4:0] OFF_ACCEL    = 5'h0C;
  localparam logic [4:0] OFF_STEPS    = 5'h10;
  localparam logic [4:0] OFF_REMAIN   = 5'h14;
  localparam logic [4:0] OFF_RAMP_DIV = 5'h18;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_DIR    = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_ABORTED  = 2;
  localparam int STAT_STATE_LO = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEL  = 2'd1,
    ST_CRUISE = 2'd2,
    ST_DECEL  = 2'd3
  } state_t;

  // Merge a bus write into an existing 32-bit register honouring byte enables.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = be[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/motor_sequencer_ramp_ticker.sv
// ramp_ticker: 32-bit down-counting prescaler. Emits a one-cycle tick each
// time the count reaches zero, then reloads; clear forces a reload.
module ramp_ticker (
  input  logic        clk_sys,
  input  logic        rst_b,
  input  logic        clear,
  input  logic        enable,
  input  logic [31:0] load_val,
  output logic        tick
);

  logic [31:0] cnt_q;

  assign tick = enable && (cnt_q == '0);

  // Terminal-count down-counter with reload on tick or clear.
  always_ff @(posedge clk_sys) begin
    if (!rst_b) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= load_val;
    end else if (enable) begin
      cnt_q <= tick ? load_val : cnt_q - 32'd1;
    end
  end

endmodule

// File: rtl/motor_sequencer.sv
// motor_sequencer: memory-mapped trapezoidal-ramp motion controller.
// Optional feature: define MOTOR_SEQ_IRQ_EN to implement IRQ_EN and irq_out.
//
// state  | meaning
// IDLE   | no move; speed parked at MIN_SPEED, step_enable low
// ACCEL  | ramping speed up by ACCEL per tick, counting ramp steps
// CRUISE | holding TARGET speed
// DECEL  | ramping down towards MIN_SPEED until REMAIN hits 0
module motor_sequencer
  import motor_seq_pkg::*;
#(
  parameter logic [31:0]        BASE_ADDR = 32'h1000_0000,
  parameter int unsigned        SPEED_W   = 16,
  parameter logic [SPEED_W-1:0] MIN_SPEED = SPEED_W'(10)
) (
  input  logic               clk_in,
  input  logic               reset_n_in,
  input  logic [31:0]        addr_in,
  input  logic [31:0]        data_in,
  input  logic [3:0]         byte_en_in,
  input  logic               wr_in,
  input  logic               rd_in,
  output logic [31:0]        data_out,
  input  logic               step_pulse_in,
  output logic [SPEED_W-1:0] speed_out,
  output logic               step_enable_out,
  output logic               dir_out,
  output logic               busy_out,
  output logic               irq_out
);

  state_t             state_q, state_n;
  logic [SPEED_W-1:0] speed_q, speed_n, target_q, accel_q;
  logic [SPEED_W:0]   sum_up, floor_lvl;
  logic [31:0]        steps_q, remain_q, remain_n, ramp_steps_q, ramp_steps_n, ramp_div_q;
  logic [31:0]        merged_target, merged_accel, merged_steps, merged_div, rdata;
  logic [4:0]         word_off;
  logic               dir_q, irq_en_q, done_q, aborted_q, done_d, aborted_d, step_prev_q;
  logic               sel, wr_hit, rd_hit, wr_ctrl, start_req, abort_req, w1c_done, w1c_aborted;
  logic               busy, step_edge, tick, ticker_clear, set_done, set_aborted;
  logic               unused_bits;

  assign sel         = (addr_in[31:5] == BASE_ADDR[31:5]);
  assign word_off    = {addr_in[4:2], 2'b00};
  assign wr_hit      = wr_in & sel;
  assign rd_hit      = rd_in & sel;
  assign wr_ctrl     = wr_hit && (word_off == OFF_CTRL) && byte_en_in[0];
  assign start_req   = wr_ctrl & data_in[CTRL_START];
  assign abort_req   = wr_ctrl & data_in[CTRL_ABORT];
  assign w1c_done    = wr_hit && (word_off == OFF_STATUS) && byte_en_in[0] && data_in[STAT_DONE];
  assign w1c_aborted = wr_hit && (word_off == OFF_STATUS) && byte_en_in[0] && data_in[STAT_ABORTED];

  assign busy      = (state_q != ST_IDLE);
  assign step_edge = step_pulse_in & ~step_prev_q;
  assign sum_up    = {1'b0, speed_q} + {1'b0, accel_q};
  assign floor_lvl = {1'b0, MIN_SPEED} + {1'b0, accel_q};

  // A fresh DONE/ABORTED event beats a simultaneous write-one-to-clear.
  assign done_d    = set_done | (done_q & ~w1c_done);
  assign aborted_d = set_aborted | (aborted_q & ~w1c_aborted);

  assign merged_target = be_merge(32'(target_q), data_in, byte_en_in);
  assign merged_accel  = be_merge(32'(accel_q), data_in, byte_en_in);
  assign merged_steps  = be_merge(steps_q, data_in, byte_en_in);
  assign merged_div    = be_merge(ramp_div_q, data_in, byte_en_in);
  assign unused_bits   = ^{addr_in[1:0], merged_target[31:SPEED_W], merged_accel[31:SPEED_W]};

  assign busy_out        = busy;
  assign step_enable_out = busy;
  assign speed_out       = speed_q;
  assign dir_out         = dir_q;

  ramp_ticker u_ticker (
    .clk_sys  (clk_in),
    .rst_b    (reset_n_in),
    .clear    (ticker_clear),
    .enable   (busy),
    .load_val (ramp_div_q),
    .tick     (tick)
  );

  // Next-state, speed ramp and step bookkeeping.
  always_comb begin
    state_n      = state_q;
    speed_n      = speed_q;
    remain_n     = remain_q;
    ramp_steps_n = ramp_steps_q;
    set_done     = 1'b0;
    set_aborted  = 1'b0;
    ticker_clear = 1'b0;
    if (state_q == ST_IDLE) begin
      if (start_req) begin
        ticker_clear = 1'b1;
        if (steps_q == '0) begin
          set_done = 1'b1;
        end else begin
          remain_n     = steps_q;
          ramp_steps_n = '0;
          speed_n      = MIN_SPEED;
          state_n      = (target_q <= MIN_SPEED) ? ST_CRUISE : ST_ACCEL;
        end
      end
    end else if (abort_req) begin
      state_n     = ST_IDLE;
      set_aborted = 1'b1;
      speed_n     = MIN_SPEED;
    end else begin
      if (step_edge) begin
        remain_n = remain_q - 32'd1;
        if (state_q == ST_ACCEL) ramp_steps_n = ramp_steps_q + 32'd1;
      end
      if (tick && state_q == ST_ACCEL) begin
        speed_n = (sum_up >= {1'b0, target_q}) ? target_q : sum_up[SPEED_W-1:0];
      end else if (tick && state_q == ST_DECEL) begin
        speed_n = ({1'b0, speed_q} < floor_lvl) ? MIN_SPEED : speed_q - accel_q;
      end
      if (remain_n == '0) begin
        state_n  = ST_IDLE;
        set_done = 1'b1;
        speed_n  = MIN_SPEED;
      end else if (state_q != ST_DECEL && remain_n <= ramp_steps_n) begin
        state_n = ST_DECEL;
      end else if (state_q == ST_ACCEL && speed_n == target_q) begin
        state_n = ST_CRUISE;
      end
    end
  end

  // FSM state and motion datapath registers.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state_q      <= ST_IDLE;
      speed_q      <= MIN_SPEED;
      remain_q     <= '0;
      ramp_steps_q <= '0;
      step_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_n;
      speed_q      <= speed_n;
      remain_q     <= remain_n;
      ramp_steps_q <= ramp_steps_n;
      step_prev_q  <= step_pulse_in;
    end
  end

  // Configuration registers; move parameters are frozen while busy.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      target_q   <= MIN_SPEED;
      accel_q    <= SPEED_W'(1);
      steps_q    <= '0;
      ramp_div_q <= '0;
      dir_q      <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      done_q    <= done_d;
      aborted_q <= aborted_d;
      if (wr_hit && !busy) begin
        case (word_off)
          OFF_TARGET:   target_q   <= merged_target[SPEED_W-1:0];
          OFF_ACCEL:    accel_q    <= merged_accel[SPEED_W-1:0];
          OFF_STEPS:    steps_q    <= merged_steps;
          OFF_RAMP_DIV: ramp_div_q <= merged_div;
          OFF_CTRL:     if (byte_en_in[0]) dir_q <= data_in[CTRL_DIR];
          default: ;
        endcase
      end
    end
  end

`ifdef MOTOR_SEQ_IRQ_EN
  logic irq_en_d;
  assign irq_en_d = wr_ctrl ? data_in[CTRL_IRQ_EN] : irq_en_q;

  // IRQ enable and level interrupt built from next-state values so irq tracks DONE without lag.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      irq_en_q <= 1'b0;
      irq_out  <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_out  <= done_d & irq_en_d;
    end
  end
`else
  assign irq_en_q = 1'b0;
  assign irq_out  = 1'b0;
`endif

  // Read mux for the selected register.
  always_comb begin
    rdata = '0;
    case (word_off)
      OFF_CTRL:     rdata = {28'b0, irq_en_q, dir_q, 2'b00};
      OFF_STATUS:   rdata = {26'b0, 2'(state_q), 1'b0, aborted_q, done_q, busy};
      OFF_TARGET:   rdata = 32'(target_q);
      OFF_ACCEL:    rdata = 32'(accel_q);
      OFF_STEPS:    rdata = steps_q;
      OFF_REMAIN:   rdata = remain_q;
      OFF_RAMP_DIV: rdata = ramp_div_q;
      default:      rdata = '0;
    endcase
  end

  // Registered read data, zero when not selected so buses can be ORed.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) data_out <= '0;
    else             data_out <= rd_hit ? rdata : '0;
  end

endmodule

// File: tb/tb_motor_sequencer.sv
// tb_motor_sequencer: scoreboard bench for motor_sequencer. Expected read data
// and expected speed changes are queued when stimulus is driven and popped when
// the DUT produces them. Honours MOTOR_SEQ_IRQ_EN to match the DUT build.
module tb_motor_sequencer;
  import motor_seq_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef MOTOR_SEQ_IRQ_EN
  localparam logic [31:0] IRQ_ON = 32'd1;
`else
  localparam logic [31:0] IRQ_ON = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        reset_n_in = 1'b0;
  logic [31:0] addr_in = '0, data_in = '0, data_out;
  logic [3:0]  byte_en_in = '0;
  logic        wr_in = 1'b0, rd_in = 1'b0, step_pulse_in = 1'b0;
  logic [15:0] speed_out;
  logic        step_enable_out, dir_out, busy_out, irq_out;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
    int          cyc;
  } exp_t;
  exp_t rd_q[$];
  exp_t spd_q[$];

  always #20 clk = ~clk;

  motor_sequencer dut (
    .clk_in          (clk),
    .reset_n_in      (reset_n_in),
    .addr_in         (addr_in),
    .data_in         (data_in),
    .byte_en_in      (byte_en_in),
    .wr_in           (wr_in),
    .rd_in           (rd_in),
    .data_out        (data_out),
    .step_pulse_in   (step_pulse_in),
    .speed_out       (speed_out),
    .step_enable_out (step_enable_out),
    .dir_out         (dir_out),
    .busy_out        (busy_out),
    .irq_out         (irq_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ra(input logic [4:0] off);
    return BASE | 32'(off);
  endfunction

  task automatic rd_issue(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    exp_t e;
    addr_in = addr;
    rd_in   = 1'b1;
    e.tag = tag; e.val = exp; e.cyc = 0;
    rd_q.push_back(e);
  endtask

  task automatic rd_collect();
    exp_t e;
    e = rd_q.pop_front();
    chk(e.tag, data_out, e.val);
  endtask

  task automatic bus_rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    @(negedge clk);
    rd_issue(addr, exp, tag);
    @(negedge clk);
    rd_in = 1'b0;
    rd_collect();
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    addr_in = addr; data_in = data; byte_en_in = be; wr_in = 1'b1;
    @(negedge clk);
    wr_in = 1'b0; byte_en_in = '0;
  endtask

  task automatic step();
    @(negedge clk);
    step_pulse_in = 1'b1;
    @(negedge clk);
    step_pulse_in = 1'b0;
  endtask

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [15:0] last_spd;
    bit          pending;
    int          k_end;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_speed", 32'(speed_out), 32'd10);
    chk("rst_busy", 32'(busy_out), 32'd0);
    chk("rst_sten", 32'(step_enable_out), 32'd0);
    chk("rst_dir", 32'(dir_out), 32'd0);
    chk("rst_irq", 32'(irq_out), 32'd0);
    chk("rst_dout", data_out, 32'd0);
    reset_n_in = 1'b1;

    bus_rd(ra(OFF_CTRL), 32'd0, "rar_ctrl");
    bus_rd(ra(OFF_STATUS), 32'd0, "rar_status");
    bus_rd(ra(OFF_TARGET), 32'd10, "rar_target");
    bus_rd(ra(OFF_ACCEL), 32'd1, "rar_accel");
    bus_rd(ra(OFF_STEPS), 32'd0, "rar_steps");
    bus_rd(ra(OFF_REMAIN), 32'd0, "rar_remain");
    bus_rd(ra(OFF_RAMP_DIV), 32'd0, "rar_rampdiv");
    bus_rd(ra(5'h1C), 32'd0, "rar_1c");
    @(negedge clk);
    chk("rd_idle_zero", data_out, 32'd0);

    // Byte enables
    bus_wr(ra(OFF_TARGET), 32'hFFFF_FF22, 4'b0001);
    bus_rd(ra(OFF_TARGET), 32'h22, "be_byte0");
    bus_wr(ra(OFF_TARGET), 32'h0000_3300, 4'b0010);
    bus_rd(ra(OFF_TARGET), 32'h3322, "be_byte1");

    // Zero-step start
    bus_wr(ra(OFF_CTRL), 32'h1, 4'hF);
    chk("zs_busy", 32'(busy_out), 32'd0);
    chk("zs_sten", 32'(step_enable_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("zs_busy_hold", 32'(busy_out | step_enable_out), 32'd0);
    end
    bus_rd(ra(OFF_STATUS), 32'h02, "zs_status");

    // Trapezoid
    bus_wr(ra(OFF_STATUS), 32'h6, 4'hF);
    bus_wr(ra(OFF_TARGET), 32'd40, 4'hF);
    bus_wr(ra(OFF_ACCEL), 32'd5, 4'hF);
    bus_wr(ra(OFF_RAMP_DIV), 32'd3, 4'hF);
    bus_wr(ra(OFF_STEPS), 32'd100, 4'hF);
    for (int i = 1; i <= 6; i++) begin
      e.tag = "trap_spd"; e.val = 32'(10 + 5 * i); e.cyc = 4 * i;
      spd_q.push_back(e);
    end
    e.tag = "trap_spd_end"; e.val = 32'd10; e.cyc = 5001;
    spd_q.push_back(e);
    bus_wr(ra(OFF_CTRL), 32'h1, 4'hF);
    chk("trap_busy", 32'(busy_out), 32'd1);
    chk("trap_sten", 32'(step_enable_out), 32'd1);
    chk("trap_spd0", 32'(speed_out), 32'd10);
    last_spd = speed_out;
    pending  = 1'b0;
    k_end    = -1;
    for (int k = 1; k <= 6000; k++) begin
      @(negedge clk);
      step_pulse_in = (k % 50 == 0);
      rd_in = 1'b0;
      if (speed_out != last_spd) begin
        if (spd_q.size() == 0) begin
          chk("trap_spd_extra", 32'(speed_out), 32'(last_spd));
        end else begin
          e = spd_q.pop_front();
          chk(e.tag, 32'(speed_out), e.val);
          chk("trap_spd_cyc", 32'(k), 32'(e.cyc));
        end
        last_spd = speed_out;
      end
      if (pending) begin
        rd_collect();
        pending = 1'b0;
      end
      if (k == 30) begin
        rd_issue(ra(OFF_STATUS), 32'h21, "trap_cruise");
        pending = 1'b1;
      end
      if (k == 4020) begin
        rd_issue(ra(OFF_REMAIN), 32'd20, "trap_remain_mid");
        pending = 1'b1;
      end
      if (!busy_out) begin
        k_end = k;
        break;
      end
    end
    step_pulse_in = 1'b0;
    rd_in = 1'b0;
    chk("trap_end_cyc", 32'(k_end), 32'd5001);
    chk("trap_spd_left", 32'(spd_q.size()), 32'd0);
    chk("trap_end_sten", 32'(step_enable_out), 32'd0);
    chk("trap_end_speed", 32'(speed_out), 32'd10);
    bus_rd(ra(OFF_STATUS), 32'h02, "trap_done");
    bus_rd(ra(OFF_REMAIN), 32'd0, "trap_remain0");

    // Triangle profile
    bus_wr(ra(OFF_STATUS), 32'h2, 4'hF);
    bus_wr(ra(OFF_TARGET), 32'd1000, 4'hF);
    bus_wr(ra(OFF_ACCEL), 32'd1, 4'hF);
    bus_wr(ra(OFF_RAMP_DIV), 32'd0, 4'hF);
    bus_wr(ra(OFF_STEPS), 32'd6, 4'hF);
    bus_wr(ra(OFF_CTRL), 32'h5, 4'hF);
    chk("tri_dir", 32'(dir_out), 32'd1);
    step();
    step();
    bus_rd(ra(OFF_STATUS), 32'h11, "tri_accel_2");
    step();
    bus_rd(ra(OFF_STATUS), 32'h31, "tri_decel_3");
    bus_rd(ra(OFF_REMAIN), 32'd3, "tri_remain_3");
    chk("tri_below_tgt", 32'(speed_out < 16'd1000), 32'd1);
    step();
    step();
    chk("tri_busy_5", 32'(busy_out), 32'd1);
    step();
    chk("tri_busy_6", 32'(busy_out), 32'd0);
    chk("tri_speed_end", 32'(speed_out), 32'd10);
    bus_rd(ra(OFF_STATUS), 32'h02, "tri_done");

    // Abort mid-cruise, rejected write while busy
    bus_wr(ra(OFF_STATUS), 32'h2, 4'hF);
    bus_wr(ra(OFF_TARGET), 32'd20, 4'hF);
    bus_wr(ra(OFF_ACCEL), 32'd10, 4'hF);
    bus_wr(ra(OFF_STEPS), 32'd100, 4'hF);
    bus_wr(ra(OFF_CTRL), 32'h1, 4'hF);
    repeat (3) @(negedge clk);
    bus_rd(ra(OFF_STATUS), 32'h21, "ab_cruise");
    for (int i = 0; i < 63; i++) step();
    bus_rd(ra(OFF_REMAIN), 32'd37, "ab_remain_pre");
    bus_wr(ra(OFF_TARGET), 32'd50, 4'hF);
    bus_rd(ra(OFF_TARGET), 32'd20, "ab_target_locked");
    bus_wr(ra(OFF_CTRL), 32'h2, 4'hF);
    chk("ab_sten", 32'(step_enable_out), 32'd0);
    chk("ab_busy", 32'(busy_out), 32'd0);
    bus_rd(ra(OFF_STATUS), 32'h04, "ab_status");
    bus_rd(ra(OFF_REMAIN), 32'd37, "ab_remain_frozen");

    // Interrupt
    bus_wr(ra(OFF_STATUS), 32'h6, 4'hF);
    bus_wr(ra(OFF_TARGET), 32'd10, 4'hF);
    bus_wr(ra(OFF_STEPS), 32'd2, 4'hF);
    bus_wr(ra(OFF_CTRL), 32'h9, 4'hF);
    chk("irq_busy", 32'(busy_out), 32'd1);
    chk("irq_low_busy", 32'(irq_out), 32'd0);
    step();
    step();
    chk("irq_done_busy", 32'(busy_out), 32'd0);
    chk("irq_set", 32'(irq_out), IRQ_ON);
    bus_rd(ra(OFF_CTRL), IRQ_ON << 3, "irq_ctrl_rd");
    bus_wr(ra(OFF_STATUS), 32'h2, 4'hF);
    chk("irq_clr", 32'(irq_out), 32'd0);
    bus_rd(ra(OFF_STATUS), 32'd0, "irq_status_clr");

    // Window decode
    bus_rd(32'h2000_0004, 32'd0, "win_outside");
    bus_rd(BASE + 32'h20, 32'd0, "win_past_end");
    bus_wr(32'h2000_0008, 32'h55, 4'hF);
    bus_rd(ra(OFF_TARGET), 32'd10, "win_wr_ignored");
    bus_wr(ra(5'h1C), 32'hFFFF_FFFF, 4'hF);
    bus_rd(ra(5'h1C), 32'd0, "win_1c");

    // Reset mid-move
    bus_wr(ra(OFF_TARGET), 32'd40, 4'hF);
    bus_wr(ra(OFF_ACCEL), 32'd5, 4'hF);
    bus_wr(ra(OFF_STEPS), 32'd50, 4'hF);
    bus_wr(ra(OFF_CTRL), 32'h5, 4'hF);
    repeat (3) @(negedge clk);
    reset_n_in = 1'b0;
    @(negedge clk);
    chk("mrst_speed", 32'(speed_out), 32'd10);
    chk("mrst_busy", 32'(busy_out), 32'd0);
    chk("mrst_sten", 32'(step_enable_out), 32'd0);
    chk("mrst_dir", 32'(dir_out), 32'd0);
    reset_n_in = 1'b1;
    bus_rd(ra(OFF_TARGET), 32'd10, "mrst_target");
    bus_rd(ra(OFF_STATUS), 32'd0, "mrst_status");
    bus_rd(ra(OFF_REMAIN), 32'd0, "mrst_remain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
